// File: rtl/palette_lut_banked.sv
// Banked, run-time writable RGB palette with a 2-stage registered lookup and a bank switch that
// takes effect only at a frame boundary. Define PALETTE_FADE_EN to add a fade_level input and a 3rd stage.
module palette_lut_banked #(
  parameter int INDEX_W = 4,
  parameter int CHAN_W  = 4,
  parameter int BANKS   = 2,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  pix_valid_in,
  input  logic [INDEX_W-1:0]    pix_index,
  output logic                  pix_valid_out,
  output logic [CHAN_W-1:0]     red,
  output logic [CHAN_W-1:0]     green,
  output logic [CHAN_W-1:0]     blue,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [BANK_W-1:0]     wr_bank,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [3*CHAN_W-1:0]   wr_data,
  input  logic                  bank_sel_stb,
  input  logic [BANK_W-1:0]     bank_sel_req,
  input  logic                  frame_start,
`ifdef PALETTE_FADE_EN
  input  logic [CHAN_W-1:0]     fade_level,
`endif
  output logic [BANK_W-1:0]     active_bank
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int RGB_W   = 3 * CHAN_W;

  logic [RGB_W-1:0]   r_pal [BANKS][ENTRIES];
  logic [BANK_W-1:0]  r_active_bank;
  logic [BANK_W-1:0]  r_pend_bank;
  logic               r_pend_valid;

  logic               r_s1_valid;
  logic [INDEX_W-1:0] r_s1_index;
  logic [BANK_W-1:0]  r_s1_bank;
  logic               r_s2_valid;
  logic [RGB_W-1:0]   r_s2_rgb;

  logic               w_wr_fire;
  logic               w_wr_bank_ok;
  logic               w_req_ok;
  logic               w_switch_valid;
  logic [BANK_W-1:0]  w_switch_bank;
  logic [RGB_W-1:0]   w_rgb_out;
  logic               w_valid_out;

  // The displayed bank is locked against writes during active video so a frame never tears.
  assign wr_ready     = !Reset && !(pix_valid_in && (wr_bank == r_active_bank));
  assign w_wr_fire    = wr_valid && wr_ready;
  assign w_wr_bank_ok = (32'(wr_bank) < BANKS);
  assign w_req_ok     = bank_sel_stb && (32'(bank_sel_req) < BANKS);

  always_comb begin
    w_switch_valid = r_pend_valid;
    w_switch_bank  = r_pend_bank;
    if (w_req_ok) begin
      w_switch_valid = 1'b1;
      w_switch_bank  = bank_sel_req;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          r_pal[b][e] <= '0;
        end
      end
    end else if (w_wr_fire && w_wr_bank_ok) begin
      r_pal[wr_bank][wr_index] <= wr_data;
    end
  end

  // A strobe coinciding with frame_start is folded into the switch decision of that same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_active_bank <= '0;
      r_pend_bank   <= '0;
      r_pend_valid  <= 1'b0;
    end else if (frame_start && w_switch_valid) begin
      r_active_bank <= w_switch_bank;
      r_pend_valid  <= 1'b0;
    end else if (w_req_ok) begin
      r_pend_bank  <= bank_sel_req;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_index <= '0;
      r_s1_bank  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rgb   <= '0;
    end else begin
      r_s1_valid <= pix_valid_in;
      r_s1_index <= pix_index;
      r_s1_bank  <= r_active_bank;
      r_s2_valid <= r_s1_valid;
      r_s2_rgb   <= r_s1_valid ? r_pal[r_s1_bank][r_s1_index] : '0;
    end
  end

`ifdef PALETTE_FADE_EN
  logic [2*CHAN_W-1:0] w_fade_mult;
  logic [RGB_W-1:0]    w_faded;
  logic                r_s3_valid;
  logic [RGB_W-1:0]    r_s3_rgb;

  // fade_level+1 is widened first so the all-ones level scales by exactly 2^CHAN_W (identity).
  assign w_fade_mult = {{CHAN_W{1'b0}}, fade_level} + (2*CHAN_W)'(1);

  for (genvar g = 0; g < 3; g++) begin : g_fade
    logic [2*CHAN_W-1:0] w_prod;
    assign w_prod = {{CHAN_W{1'b0}}, r_s2_rgb[g*CHAN_W +: CHAN_W]} * w_fade_mult;
    assign w_faded[g*CHAN_W +: CHAN_W] = w_prod[2*CHAN_W-1:CHAN_W];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s3_valid <= 1'b0;
      r_s3_rgb   <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_s3_rgb   <= r_s2_valid ? w_faded : '0;
    end
  end

  assign w_valid_out = r_s3_valid;
  assign w_rgb_out   = r_s3_rgb;
`else
  assign w_valid_out = r_s2_valid;
  assign w_rgb_out   = r_s2_rgb;
`endif

  assign pix_valid_out = w_valid_out;
  assign red           = w_rgb_out[3*CHAN_W-1 -: CHAN_W];
  assign green         = w_rgb_out[2*CHAN_W-1 -: CHAN_W];
  assign blue          = w_rgb_out[CHAN_W-1:0];
  assign active_bank   = r_active_bank;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Directed self-checking bench for palette_lut_banked in its default build (INDEX_W=4, CHAN_W=4,
// BANKS=2, 2-cycle lookup latency).
module tb_palette_lut_banked;

  logic        Clk;
  logic        Reset;
  logic        pix_valid_in;
  logic [3:0]  pix_index;
  logic        pix_valid_out;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_data;
  logic        bank_sel_stb;
  logic [0:0]  bank_sel_req;
  logic        frame_start;
  logic [0:0]  active_bank;

  int checks;
  int failures;
  logic [11:0] expBank0 [16];

  palette_lut_banked #(.INDEX_W(4), .CHAN_W(4), .BANKS(2)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .pix_valid_in(pix_valid_in),
    .pix_index(pix_index),
    .pix_valid_out(pix_valid_out),
    .red(red),
    .green(green),
    .blue(blue),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_bank(wr_bank),
    .wr_index(wr_index),
    .wr_data(wr_data),
    .bank_sel_stb(bank_sel_stb),
    .bank_sel_req(bank_sel_req),
    .frame_start(frame_start),
    .active_bank(active_bank)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one clock and settle just after the edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [3:0] idx);
    pix_valid_in = pv;
    pix_index    = idx;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] entryFor(input int i);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    r = 4'(i);
    g = 4'(15 - i);
    b = 4'(i * 3);
    return {r, g, b};
  endfunction

  initial begin
    checks       = 0;
    failures     = 0;
    Reset        = 1'b1;
    pix_valid_in = 1'b1;
    pix_index    = 4'd5;
    wr_valid     = 1'b1;
    wr_bank      = 1'b1;
    wr_index     = 4'd0;
    wr_data      = 12'hABC;
    bank_sel_stb = 1'b0;
    bank_sel_req = 1'b0;
    frame_start  = 1'b0;
    #1;
    checkOutput("ready_during_reset", 16'(wr_ready), 16'h0);
    tick();
    tick();
    checkOutput("reset_pipe", 16'({pix_valid_out, red, green, blue}), 16'h0000);
    checkOutput("reset_bank", 16'(active_bank), 16'h0);

    // Index 5 of a cleared palette comes back valid and black.
    Reset    = 1'b0;
    wr_valid = 1'b0;
    tick();
    tick();
    checkOutput("first_pixel", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h000});

    pix_valid_in = 1'b0;
    wr_valid     = 1'b1;
    wr_bank      = 1'b0;
    wr_index     = 4'd3;
    wr_data      = 12'h0BE;
    #1;
    checkOutput("ready_idle", 16'(wr_ready), 16'h1);
    tick();
    wr_valid = 1'b0;
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b0, 4'd0);
    checkOutput("read_idx3", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h0BE});
    applyStimulus(1'b0, 4'd0);
    checkOutput("blanking", 16'({pix_valid_out, red, green, blue}), 16'h0000);

    for (int i = 0; i < 16; i++) begin
      expBank0[i] = (i == 3) ? 12'h0BE : entryFor(i);
      if (i != 3) begin
        wr_valid = 1'b1;
        wr_bank  = 1'b0;
        wr_index = 4'(i);
        wr_data  = entryFor(i);
        tick();
      end
    end
    wr_valid = 1'b0;

    for (int i = 0; i <= 16; i++) begin
      applyStimulus(i < 16, 4'(i));
      if (i >= 1) begin
        checkOutput($sformatf("stream_%0d", i - 1), 16'({pix_valid_out, red, green, blue}),
                    {3'b0, 1'b1, expBank0[i-1]});
      end
    end

    // Active video on bank 0: bank 0 is locked, bank 1 stays writable.
    pix_valid_in = 1'b1;
    pix_index    = 4'd0;
    wr_valid     = 1'b1;
    wr_bank      = 1'b0;
    wr_index     = 4'd3;
    wr_data      = 12'hFFF;
    #1;
    checkOutput("ready_blocked", 16'(wr_ready), 16'h0);
    tick();
    wr_bank  = 1'b1;
    wr_index = 4'd7;
    wr_data  = 12'hD10;
    #1;
    checkOutput("ready_other_bank", 16'(wr_ready), 16'h1);
    tick();
    wr_valid = 1'b0;
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b0, 4'd0);
    checkOutput("blocked_no_update", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h0BE});

    bank_sel_stb = 1'b1;
    bank_sel_req = 1'b1;
    tick();
    bank_sel_stb = 1'b0;
    checkOutput("bank_pending_hold", 16'(active_bank), 16'h0);
    tick();
    tick();
    checkOutput("bank_still_0", 16'(active_bank), 16'h0);

    // The pixel sharing the frame_start edge still uses bank 0; the next one uses bank 1.
    pix_valid_in = 1'b1;
    pix_index    = 4'd7;
    frame_start  = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("bank_switched", 16'(active_bank), 16'h1);
    tick();
    checkOutput("pix_old_bank", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, expBank0[7]});
    pix_valid_in = 1'b0;
    tick();
    checkOutput("pix_new_bank", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'hD10});

    applyStimulus(1'b1, 4'd7);
    pix_valid_in = 1'b0;
    wr_valid     = 1'b1;
    wr_bank      = 1'b1;
    wr_index     = 4'd7;
    wr_data      = 12'h8DE;
    #1;
    checkOutput("ready_rbw", 16'(wr_ready), 16'h1);
    tick();
    wr_valid = 1'b0;
    checkOutput("read_before_write", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'hD10});
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b0, 4'd0);
    checkOutput("read_after_write", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h8DE});

    // A later strobe replaces the earlier pending request.
    bank_sel_stb = 1'b1;
    bank_sel_req = 1'b1;
    tick();
    bank_sel_req = 1'b0;
    tick();
    bank_sel_stb = 1'b0;
    frame_start  = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("stb_overwrite", 16'(active_bank), 16'h0);

    bank_sel_stb = 1'b1;
    bank_sel_req = 1'b1;
    frame_start  = 1'b1;
    tick();
    bank_sel_stb = 1'b0;
    frame_start  = 1'b0;
    checkOutput("stb_with_frame", 16'(active_bank), 16'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("pending_cleared", 16'(active_bank), 16'h1);

    // Reset mid-operation with a pixel in flight, a pending request and a write presented.
    bank_sel_stb = 1'b1;
    bank_sel_req = 1'b1;
    pix_valid_in = 1'b1;
    pix_index    = 4'd7;
    tick();
    bank_sel_stb = 1'b0;
    pix_valid_in = 1'b0;
    Reset        = 1'b1;
    wr_valid     = 1'b1;
    wr_bank      = 1'b0;
    wr_index     = 4'd5;
    wr_data      = 12'h123;
    tick();
    Reset    = 1'b0;
    wr_valid = 1'b0;
    checkOutput("midreset_pipe", 16'({pix_valid_out, red, green, blue}), 16'h0000);
    checkOutput("midreset_bank", 16'(active_bank), 16'h0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("midreset_flushed", 16'(pix_valid_out), 16'h0);
    checkOutput("midreset_pending_dropped", 16'(active_bank), 16'h0);
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd5);
    checkOutput("midreset_cleared", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h000});
    applyStimulus(1'b0, 4'd0);
    checkOutput("midreset_write_dropped", 16'({pix_valid_out, red, green, blue}), {3'b0, 1'b1, 12'h000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
